// File: rtl/ex_dispatch.sv
// ex_dispatch: dual-lane issue gate for ALU-ic, ALU-m and lane0 FPU units.
// Macro EX_DISPATCH_FPU_EN enables the FPU path; otherwise lane0 type 10 is illegal.
module ex_dispatch #(
  parameter int FPU_LAT = 4,
  parameter int M_LAT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic       issue_vld_0,
  input  logic       issue_vld_1,
  input  logic [1:0] issue_type_0,
  input  logic       issue_type_1,
  output logic       issue_ready,
  output logic       alu_ic_en_0,
  output logic       alu_ic_en_1,
  output logic       alu_m_en_0,
  output logic       alu_m_en_1,
  output logic       fpu_start,
  output logic       fpu_en,
  output logic       fpu_busy,
  output logic       illegal
);

  localparam logic [2:0] MLoad = 3'(M_LAT - 1);
  localparam logic [2:0] MLat  = 3'(M_LAT);
  localparam logic [2:0] FLat  = 3'(FPU_LAT);

  logic [2:0] m0Cnt;
  logic [2:0] m1Cnt;
  logic       isIc0;
  logic       isM0;
  logic       isFpu;
  logic       isIll;
  logic       isIc1;
  logic       isM1;
  logic       stall0;
  logic       stall1;
  logic       fpuStall;
  logic       accept;

  // Counters hold cycles left before the enable cycle; 0 means idle.
  function automatic logic [2:0] nextCnt(
    input logic [2:0] cnt,
    input logic       load,
    input logic [2:0] loadVal,
    input logic       clr
  );
    if (clr)
      return 3'd0;
    else if (load)
      return loadVal;
    else if (cnt != 3'd0)
      return cnt - 3'd1;
    else
      return 3'd0;
  endfunction

  always_comb begin
    isIc0 = 1'b0;
    isM0  = 1'b0;
    isFpu = 1'b0;
    isIll = 1'b0;
    if (issue_vld_0) begin
      unique case (issue_type_0)
        2'b00: isIc0 = 1'b1;
        2'b01: isM0  = 1'b1;
`ifdef EX_DISPATCH_FPU_EN
        2'b10: isFpu = 1'b1;
`else
        2'b10: isIll = 1'b1;
`endif
        default: isIll = 1'b1;
      endcase
    end
  end

  assign isIc1 = issue_vld_1 & ~issue_type_1;
  assign isM1  = issue_vld_1 & issue_type_1;

`ifdef EX_DISPATCH_FPU_EN
  logic [2:0] fCnt;
  logic       fpuHit1;
  logic       fpuHitM;

  assign fpuHit1  = (fCnt == 3'd1);
  assign fpuHitM  = (fCnt == MLat);
  assign fpuStall = isFpu & ((fpu_busy & ~fpu_en) | (m0Cnt == FLat));
`else
  logic fpuHit1;
  logic fpuHitM;

  assign fpuHit1  = 1'b0;
  assign fpuHitM  = 1'b0;
  assign fpuStall = 1'b0;
`endif

  assign stall0 = (isIc0 & ((m0Cnt == 3'd1) | fpuHit1))
                | (isM0 & ((m0Cnt != 3'd0) | fpuHitM))
                | fpuStall;
  assign stall1 = (isIc1 & (m1Cnt == 3'd1))
                | (isM1 & (m1Cnt != 3'd0));

  assign issue_ready = ~(stall0 | stall1);
  assign accept      = issue_valid & issue_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0Cnt       <= 3'd0;
      m1Cnt       <= 3'd0;
      alu_ic_en_0 <= 1'b0;
      alu_ic_en_1 <= 1'b0;
      alu_m_en_0  <= 1'b0;
      alu_m_en_1  <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      m0Cnt       <= nextCnt(m0Cnt, accept & isM0, MLoad, flush);
      m1Cnt       <= nextCnt(m1Cnt, accept & isM1, MLoad, flush);
      alu_ic_en_0 <= accept & isIc0;
      alu_ic_en_1 <= accept & isIc1;
      alu_m_en_0  <= ~flush & (m0Cnt == 3'd1);
      alu_m_en_1  <= ~flush & (m1Cnt == 3'd1);
      illegal     <= accept & isIll;
    end
  end

`ifdef EX_DISPATCH_FPU_EN
  localparam logic [2:0] FLoad = 3'(FPU_LAT - 1);

  // Launch pulse must coincide with the accept cycle, so it is combinational.
  assign fpu_start = rst_n & accept & isFpu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fCnt     <= 3'd0;
      fpu_en   <= 1'b0;
      fpu_busy <= 1'b0;
    end else begin
      fCnt     <= nextCnt(fCnt, accept & isFpu, FLoad, flush);
      fpu_en   <= ~flush & fpuHit1;
      fpu_busy <= ~flush & ((accept & isFpu) | (fCnt != 3'd0));
    end
  end
`else
  assign fpu_start = 1'b0;
  assign fpu_en    = 1'b0;
  assign fpu_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_dispatch.sv
// tb_ex_dispatch: randomized scoreboard bench for ex_dispatch.
// Expected enables are scheduled as absolute-cycle events and matched per cycle.
module tb_ex_dispatch;

  localparam int FL = 4;
  localparam int ML = 3;
`ifdef EX_DISPATCH_FPU_EN
  localparam bit HasFpu = 1'b1;
`else
  localparam bit HasFpu = 1'b0;
`endif

  localparam int KIC0 = 0;
  localparam int KIC1 = 1;
  localparam int KM0  = 2;
  localparam int KM1  = 3;
  localparam int KFST = 4;
  localparam int KFEN = 5;
  localparam int KILL = 6;
  localparam int KBSY = 7;
  localparam int KRD0 = 8;
  localparam int KRD1 = 9;

  typedef struct {
    int c;
    int k;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       issue_valid;
  logic       issue_vld_0;
  logic       issue_vld_1;
  logic [1:0] issue_type_0;
  logic       issue_type_1;
  logic       issue_ready;
  logic       alu_ic_en_0;
  logic       alu_ic_en_1;
  logic       alu_m_en_0;
  logic       alu_m_en_1;
  logic       fpu_start;
  logic       fpu_en;
  logic       fpu_busy;
  logic       illegal;

  ev_t   q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string names[8] = '{"alu_ic_en_0", "alu_ic_en_1", "alu_m_en_0",
                      "alu_m_en_1", "fpu_start", "fpu_en",
                      "illegal", "fpu_busy"};

  ex_dispatch #(.FPU_LAT(FL), .M_LAT(ML)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .issue_valid(issue_valid),
    .issue_vld_0(issue_vld_0),
    .issue_vld_1(issue_vld_1),
    .issue_type_0(issue_type_0),
    .issue_type_1(issue_type_1),
    .issue_ready(issue_ready),
    .alu_ic_en_0(alu_ic_en_0),
    .alu_ic_en_1(alu_ic_en_1),
    .alu_m_en_0(alu_m_en_0),
    .alu_m_en_1(alu_m_en_1),
    .fpu_start(fpu_start),
    .fpu_en(fpu_en),
    .fpu_busy(fpu_busy),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int k);
    ev_t e;
    e.c = c;
    e.k = k;
    q.push_back(e);
  endtask

  task automatic dropFrom(input int c);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].c >= c) q.delete(i);
  endtask

  task automatic take(input int c, input int k, output bit found);
    found = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].c == c && q[i].k == k) begin
        q.delete(i);
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic fail(input string what, input int act, input int exp);
    errors++;
    if (errors <= 40)
      $display("FAIL %s cycle %0d got %0d want %0d", what, cyc, act, exp);
  endtask

  // Monitor: every output is compared with the scheduled events for this cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    bit         e;
    bit         r1;
    bit         r0;
    act = {fpu_busy, illegal, fpu_en, fpu_start,
           alu_m_en_1, alu_m_en_0, alu_ic_en_1, alu_ic_en_0};
    for (int k = 0; k < 8; k++) begin
      take(cyc, k, e);
      checks++;
      if (act[k] !== e) fail(names[k], int'(act[k]), int'(e));
    end
    take(cyc, KRD1, r1);
    take(cyc, KRD0, r0);
    if (r1 || r0) begin
      checks++;
      if (issue_ready !== r1) fail("issue_ready", int'(issue_ready), int'(r1));
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c < cyc) begin
        fail("stale_event", q[i].k, q[i].c);
        q.delete(i);
      end
    end
  end

  // Reference state: absolute cycle of each unit's pending result.
  int m0Done;
  int m1Done;
  int fDone;

  initial begin
    int  n;
    int  r;
    bit  inRst;
    bit  isIc0;
    bit  isM0;
    bit  isFpu;
    bit  isIll;
    bit  stall0;
    bit  stall1;
    bit  rdy;
    bit  acc;
    rst_n        = 1'b0;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_vld_0  = 1'b0;
    issue_vld_1  = 1'b0;
    issue_type_0 = 2'b00;
    issue_type_1 = 1'b0;
    m0Done = 0;
    m1Done = 0;
    fDone  = 0;
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      #1;
      n = cyc;
      inRst = (n < 4) || (n >= 1500 && n < 1503) || (n == 2600);
      if (inRst) begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_vld_0 = 1'b0;
        issue_vld_1 = 1'b0;
        dropFrom(n);
        m0Done = 0;
        m1Done = 0;
        fDone  = 0;
        push(n, KRD1);
        continue;
      end
      rst_n = 1'b1;
      if (n < 2985) begin
        issue_valid  = ($urandom_range(0, 9) < 7);
        issue_vld_0  = ($urandom_range(0, 3) != 0);
        issue_vld_1  = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 15);
        issue_type_0 = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
        issue_type_1 = 1'($urandom_range(0, 1));
        flush        = ($urandom_range(0, 49) == 0);
      end else begin
        issue_valid = 1'b0;
        flush       = 1'b0;
      end
      isIc0 = issue_vld_0 && issue_type_0 == 2'b00;
      isM0  = issue_vld_0 && issue_type_0 == 2'b01;
      isFpu = issue_vld_0 && issue_type_0 == 2'b10 && HasFpu;
      isIll = issue_vld_0 && (issue_type_0 == 2'b11 ||
              (issue_type_0 == 2'b10 && !HasFpu));
      stall0 = (isIc0 && (m0Done == n + 1 || fDone == n + 1))
            || (isM0 && (m0Done > n || fDone == n + ML))
            || (isFpu && (fDone > n || m0Done == n + FL));
      stall1 = issue_vld_1 && (issue_type_1 ? (m1Done > n) : (m1Done == n + 1));
      rdy = !(stall0 || stall1);
      acc = issue_valid && rdy && !flush;
      if (issue_valid || (!issue_vld_0 && !issue_vld_1))
        push(n, rdy ? KRD1 : KRD0);
      if (acc) begin
        if (isIc0) push(n + 1, KIC0);
        if (isIll) push(n + 1, KILL);
        if (isM0) begin
          m0Done = n + ML;
          push(m0Done, KM0);
        end
        if (isFpu) begin
          fDone = n + FL;
          push(n, KFST);
          push(fDone, KFEN);
          for (int b = 1; b <= FL; b++) push(n + b, KBSY);
        end
        if (issue_vld_1 && !issue_type_1) push(n + 1, KIC1);
        if (issue_vld_1 && issue_type_1) begin
          m1Done = n + ML;
          push(m1Done, KM1);
        end
      end
      if (flush) begin
        dropFrom(n + 1);
        m0Done = 0;
        m1Done = 0;
        fDone  = 0;
      end
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
